ifm_fifo_ctrl: RTL and testbench
================================

# ifm_fifo_ctrl

Ping-pong scheduler for the dual-bank input-feature-map FIFO. Generates the per-bank clear, write-enable and read-enable strobes plus the `ifm_demux`/`ifm_mux` selects, so the loader fills one bank while the systolic array drains the other. It sits between the IFM DMA/loader (write side) and the PE-array feeder (read side), and owns all bank-ownership decisions.

## Interface
- `MAX_WGT_FIFO_SIZE`, 4608: depth of each bank in words; upper bound of `cfg_len`.
- `CNT_WIDTH`, 13: width of length/count fields; must satisfy 2^CNT_WIDTH > `MAX_WGT_FIFO_SIZE`.

- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; latches config and (re)initialises both banks.
- `cfg_len` in CNT_WIDTH: words per tile (per bank fill), legal 1..MAX_WGT_FIFO_SIZE.
- `wr_valid` in 1: loader presents a word on the FIFO `data_in`.
- `wr_ready` out 1: current write bank can accept a word.
- `rd_req` in 1: feeder requests one word.
- `rd_valid` out 1: FIFO `data_out` holds a valid word this cycle.
- `wr_clr_1`, `rd_clr_1`, `wr_en_1`, `rd_en_1` out 1 each: bank-1 strobes.
- `wr_clr_2`, `rd_clr_2`, `wr_en_2`, `rd_en_2` out 1 each: bank-2 strobes.
- `ifm_demux` out 1: write-bank select (0 = bank 1).
- `ifm_mux` out 1: read-bank select, aligned to `data_out`.
- `tile_done` out 1: one-cycle pulse when a bank is fully consumed.
- `busy` out 1: session active.

## Operation
- Per-bank state: EMPTY, FILL, FULL, CLR. Pointers `wr_sel`, `rd_sel`; counters `wr_cnt`, `rd_cnt` (CNT_WIDTH).
- Reset: both banks EMPTY, selects 0, counters 0, `busy`=0; every output 0.
- `start` with legal `cfg_len`: latch `cfg_len`, both banks → CLR, `wr_clr_*`/`rd_clr_*` all high next cycle, then EMPTY; `busy`=1. `start` with `cfg_len`=0 or >MAX is ignored (no state change). `start` while busy aborts the session and re-initialises identically.
- Write: `wr_ready` = `busy` and bank[`wr_sel`] ∈ {EMPTY, FILL}. Accept = `wr_valid & wr_ready`; asserts `wr_en_<wr_sel>` combinationally the same cycle. EMPTY→FILL on first accept; on accept with `wr_cnt`=`cfg_len`-1: bank → FULL, `wr_cnt`←0, `wr_sel` toggles.
- `ifm_demux` = `wr_sel` (registered state).
- Read: issue = `rd_req` and bank[`rd_sel`]=FULL; asserts `rd_en_<rd_sel>` combinationally. On issue with `rd_cnt`=`cfg_len`-1: bank → CLR, `rd_cnt`←0, `rd_sel` toggles, `tile_done` pulses next cycle.
- CLR (1 cycle): assert that bank's `wr_clr` and `rd_clr`; → EMPTY.
- Both banks run concurrently: a write to one bank and read from the other in the same cycle are both honoured. `rd_req` with no FULL bank is dropped (no strobe).

## Timing
- Write accept → `wr_en` same cycle; FIFO write on that edge.
- Read issue → `rd_valid`=1 exactly one cycle later (registered); `ifm_mux` = `rd_sel` registered at issue, so it matches `data_out` of the issuing bank.
- Last write of a bank → bank readable the following cycle (FULL visible after edge).
- Last read → CLR cycle next → bank EMPTY, `wr_ready` may rise the cycle after CLR (2 cycles after last read).
- `tile_done` one cycle after last read, concurrent with the clear strobes.
- `rst_n` low mid-transfer: all state returns to reset values on that edge; in-flight `rd_valid` dropped.

## Configuration
- `IFM_REPLAY_EN`: adds input `cfg_rep` (4 bits, passes per bank, 0 treated as 1). A bank finishing pass k < `cfg_rep` pulses only its `rd_clr` for one cycle (read pointer rewind, no read issued that cycle), stays FULL, `rd_cnt`←0; `tile_done` and CLR occur only after the final pass. Without the macro: no `cfg_rep` port, each bank read exactly once.

## Test plan
- Reset then `start`, `cfg_len`=4: all four clears high for one cycle; `busy`=1; all other outputs 0 during reset.
- Stream 8 writes, `rd_req` low: `wr_en_1` ×4 then `wr_en_2` ×4, `ifm_demux` 0→1, `wr_ready` falls after 8th write.
- Continuous `rd_req` after above: `rd_en_1` ×4, `rd_valid` lagging 1 cycle with `ifm_mux`=0, then bank-2 reads with `ifm_mux`=1; `tile_done` twice; `wr_clr_1`/`rd_clr_1` pulse one cycle after 4th read.
- Concurrent write to bank 1 while reading bank 2, `cfg_len`=3: both strobes same cycles, no lost words (scoreboard data order).
- `start` with `cfg_len`=0: ignored; `cfg_len`=4608 boundary fills completely; `rst_n` asserted mid-drain: all outputs 0 next cycle.
- `IFM_REPLAY_EN`, `cfg_rep`=3, `cfg_len`=2: bank 1 read 6 words with two `rd_clr_1`-only pulses, single `tile_done`.

Source files
------------

// File: rtl/ifm_fifo_ctrl_if.sv
// Handshake and strobe bundle between the IFM loader/feeder side and the
// ping-pong bank scheduler. When IFM_REPLAY_EN is defined, the bundle also
// carries cfg_rep (passes per bank).
interface ifm_fifo_ctrl_if #(
    parameter int CNT_WIDTH = 13
);
    logic                 start;
    logic [CNT_WIDTH-1:0] cfg_len;
`ifdef IFM_REPLAY_EN
    logic [3:0]           cfg_rep;
`endif
    logic                 wr_valid;
    logic                 wr_ready;
    logic                 rd_req;
    logic                 rd_valid;
    logic                 wr_clr_1;
    logic                 rd_clr_1;
    logic                 wr_en_1;
    logic                 rd_en_1;
    logic                 wr_clr_2;
    logic                 rd_clr_2;
    logic                 wr_en_2;
    logic                 rd_en_2;
    logic                 ifm_demux;
    logic                 ifm_mux;
    logic                 tile_done;
    logic                 busy;

`ifdef IFM_REPLAY_EN
    modport slave (
        input  start, cfg_len, cfg_rep, wr_valid, rd_req,
        output wr_ready, rd_valid, wr_clr_1, rd_clr_1, wr_en_1, rd_en_1,
               wr_clr_2, rd_clr_2, wr_en_2, rd_en_2, ifm_demux, ifm_mux,
               tile_done, busy
    );
    modport master (
        output start, cfg_len, cfg_rep, wr_valid, rd_req,
        input  wr_ready, rd_valid, wr_clr_1, rd_clr_1, wr_en_1, rd_en_1,
               wr_clr_2, rd_clr_2, wr_en_2, rd_en_2, ifm_demux, ifm_mux,
               tile_done, busy
    );
`else
    modport slave (
        input  start, cfg_len, wr_valid, rd_req,
        output wr_ready, rd_valid, wr_clr_1, rd_clr_1, wr_en_1, rd_en_1,
               wr_clr_2, rd_clr_2, wr_en_2, rd_en_2, ifm_demux, ifm_mux,
               tile_done, busy
    );
    modport master (
        output start, cfg_len, wr_valid, rd_req,
        input  wr_ready, rd_valid, wr_clr_1, rd_clr_1, wr_en_1, rd_en_1,
               wr_clr_2, rd_clr_2, wr_en_2, rd_en_2, ifm_demux, ifm_mux,
               tile_done, busy
    );
`endif
endinterface

// File: rtl/ifm_fifo_ctrl.sv
// Ping-pong scheduler for the dual-bank IFM FIFO: the loader fills one bank
// while the PE feeder drains the other. Owns bank state, write/read pointers
// and all clear/enable strobes.
// Optional feature macro IFM_REPLAY_EN: each bank is read cfg_rep times
// (0 treated as 1) with a read-pointer rewind pulse between passes.
module ifm_fifo_ctrl #(
    parameter int MAX_WGT_FIFO_SIZE = 4608,
    parameter int CNT_WIDTH         = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    ifm_fifo_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL, ST_CLR} bank_state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(MAX_WGT_FIFO_SIZE);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    bank_state_t          bank_q [2];
    logic                 wr_sel;
    logic                 rd_sel;
    logic [CNT_WIDTH-1:0] wr_cnt;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CNT_WIDTH-1:0] last_idx;   // cfg_len - 1, latched at start
    logic                 busy_q;
    logic                 rd_valid_q;
    logic                 mux_q;
    logic                 tile_done_q;
    logic [1:0]           rewind;     // per-bank read-pointer rewind pulse

    logic                 legal_start;
    logic                 wr_ready_c;
    logic                 accept;
    logic                 issue;
    logic                 wr_last;
    logic                 rd_last;
    logic                 final_pass;

`ifdef IFM_REPLAY_EN
    logic [3:0] rep_last;             // number of passes minus one
    logic [3:0] pass_cnt;
    logic [1:0] rewind_q;
    assign rewind = rewind_q;
`else
    assign rewind = 2'b00;
`endif

    // Handshake qualifiers decoded from the registered bank state.
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        legal_start = bus.start && (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN);
        wr_ready_c  = busy_q && (bank_q[wr_sel] == ST_EMPTY || bank_q[wr_sel] == ST_FILL);
        // A legal start re-initialises both banks, so no transfer is honoured that cycle.
        accept      = bus.wr_valid && wr_ready_c && !legal_start;
        issue       = bus.rd_req && (bank_q[rd_sel] == ST_FULL) && !rewind[rd_sel] && !legal_start;
        wr_last     = (wr_cnt == last_idx);
        rd_last     = (rd_cnt == last_idx);
`ifdef IFM_REPLAY_EN
        final_pass  = (pass_cnt == rep_last);
`else
        final_pass  = 1'b1;
`endif
    end

    // Bank ownership, pointers, counters and registered read-side outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q[0]   <= ST_EMPTY;
            bank_q[1]   <= ST_EMPTY;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            last_idx    <= '0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            mux_q       <= 1'b0;
            tile_done_q <= 1'b0;
`ifdef IFM_REPLAY_EN
            rep_last    <= '0;
            pass_cnt    <= '0;
            rewind_q    <= '0;
`endif
        end else if (legal_start) begin
            bank_q[0]   <= ST_CLR;
            bank_q[1]   <= ST_CLR;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            last_idx    <= bus.cfg_len - ONE;
            busy_q      <= 1'b1;
            rd_valid_q  <= 1'b0;
            mux_q       <= 1'b0;
            tile_done_q <= 1'b0;
`ifdef IFM_REPLAY_EN
            rep_last    <= (bus.cfg_rep == 4'd0) ? 4'd0 : bus.cfg_rep - 4'd1;
            pass_cnt    <= '0;
            rewind_q    <= '0;
`endif
        end else begin
            rd_valid_q  <= issue;
            tile_done_q <= issue && rd_last && final_pass;
`ifdef IFM_REPLAY_EN
            rewind_q    <= '0;
`endif
            // A clear lasts exactly one cycle.
            for (int b = 0; b < 2; b++) begin
                if (bank_q[b] == ST_CLR) bank_q[b] <= ST_EMPTY;
            end

            // Write and read banks never coincide (EMPTY/FILL vs FULL), so both may update.
            if (accept) begin
                if (wr_last) begin
                    bank_q[wr_sel] <= ST_FULL;
                    wr_cnt         <= '0;
                    wr_sel         <= ~wr_sel;
                end else begin
                    bank_q[wr_sel] <= ST_FILL;
                    wr_cnt         <= wr_cnt + ONE;
                end
            end

            if (issue) begin
                mux_q <= rd_sel;
                if (rd_last) begin
                    rd_cnt <= '0;
                    if (final_pass) begin
                        bank_q[rd_sel] <= ST_CLR;
                        rd_sel         <= ~rd_sel;
`ifdef IFM_REPLAY_EN
                        pass_cnt       <= '0;
                    end else begin
                        rewind_q[rd_sel] <= 1'b1;
                        pass_cnt         <= pass_cnt + 4'd1;
`endif
                    end
                end else begin
                    rd_cnt <= rd_cnt + ONE;
                end
            end
        end
    end

    assign bus.wr_ready  = wr_ready_c;
    assign bus.wr_en_1   = accept && !wr_sel;
    assign bus.wr_en_2   = accept && wr_sel;
    assign bus.rd_en_1   = issue && !rd_sel;
    assign bus.rd_en_2   = issue && rd_sel;
    assign bus.wr_clr_1  = (bank_q[0] == ST_CLR);
    assign bus.wr_clr_2  = (bank_q[1] == ST_CLR);
    assign bus.rd_clr_1  = (bank_q[0] == ST_CLR) || rewind[0];
    assign bus.rd_clr_2  = (bank_q[1] == ST_CLR) || rewind[1];
    assign bus.ifm_demux = wr_sel;
    assign bus.ifm_mux   = mux_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.tile_done = tile_done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ifm_fifo_ctrl.sv
// Self-checking bench for ifm_fifo_ctrl. A behavioural two-bank FIFO reacts to
// the strobes; a scoreboard queue holds the words (and source bank) expected
// on the read side, pushed when the bench completes a tile of writes.
module tb_ifm_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ifm_fifo_ctrl_if #(.CNT_WIDTH(13)) bus ();

    ifm_fifo_ctrl #(.MAX_WGT_FIFO_SIZE(4608), .CNT_WIDTH(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] data;
        logic        bank;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] tile_buf[$];
    logic [15:0] mem0[$];
    logic [15:0] mem1[$];
    int          ptr0, ptr1;
    logic [15:0] dout0, dout1;
    logic        rd_pend;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          len_cur, rep_cur, tile_idx;
    int          wr_left;
    bit          rd_on;
    logic [15:0] wr_data = 16'h0100;
    int          n_wen1, n_wen2, n_ren1, n_ren2, n_tile, n_rewind1, n_overlap;
    int          cyc, last_rd1_cyc, clr1_cyc;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [13:0] outs();
        return {bus.wr_ready, bus.rd_valid, bus.wr_clr_1, bus.rd_clr_1, bus.wr_en_1,
                bus.rd_en_1, bus.wr_clr_2, bus.rd_clr_2, bus.wr_en_2, bus.rd_en_2,
                bus.ifm_demux, bus.ifm_mux, bus.tile_done, bus.busy};
    endfunction

    function automatic logic [3:0] clrs();
        return {bus.wr_clr_1, bus.rd_clr_1, bus.wr_clr_2, bus.rd_clr_2};
    endfunction

    task automatic flush_model();
        exp_q.delete();
        tile_buf.delete();
        mem0.delete();
        mem1.delete();
        ptr0 = 0; ptr1 = 0; rd_pend = 1'b0; tile_idx = 0;
        n_wen1 = 0; n_wen2 = 0; n_ren1 = 0; n_ren2 = 0;
        n_tile = 0; n_rewind1 = 0; n_overlap = 0;
        last_rd1_cyc = 0; clr1_cyc = -100;
    endtask

    // Evaluate one cycle's outputs just before the active edge.
    task automatic observe();
        exp_t e;
        cyc++;
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("rd_data", bus.ifm_mux ? dout1 : dout0, e.data);
                check("rd_bank", bus.ifm_mux, e.bank);
            end
        end
        if (bus.rd_valid === 1'b1 || rd_pend) check("rd_valid_lag", bus.rd_valid, rd_pend);
        if (bus.tile_done === 1'b1) begin
            n_tile++;
            check("tile_done_with_clr", bus.wr_clr_1 | bus.wr_clr_2, 1);
        end
        if (bus.rd_clr_1 === 1'b1 && bus.wr_clr_1 === 1'b0) n_rewind1++;
        if (bus.wr_clr_1 === 1'b1 && bus.rd_clr_1 === 1'b1) clr1_cyc = cyc;

        if (bus.wr_clr_1 === 1'b1) begin mem0.delete(); ptr0 = 0; end
        else if (bus.rd_clr_1 === 1'b1) ptr0 = 0;
        if (bus.wr_clr_2 === 1'b1) begin mem1.delete(); ptr1 = 0; end
        else if (bus.rd_clr_2 === 1'b1) ptr1 = 0;

        rd_pend = (bus.rd_en_1 === 1'b1) || (bus.rd_en_2 === 1'b1);
        if (bus.rd_en_1 === 1'b1) begin
            dout0 = (ptr0 < mem0.size()) ? mem0[ptr0] : 16'hxxxx;
            ptr0++; n_ren1++; last_rd1_cyc = cyc;
        end
        if (bus.rd_en_2 === 1'b1) begin
            dout1 = (ptr1 < mem1.size()) ? mem1[ptr1] : 16'hxxxx;
            ptr1++; n_ren2++;
        end
        if ((bus.wr_en_1 === 1'b1 && bus.rd_en_2 === 1'b1) ||
            (bus.wr_en_2 === 1'b1 && bus.rd_en_1 === 1'b1)) n_overlap++;

        if ((bus.wr_en_1 === 1'b1 || bus.wr_en_2 === 1'b1) && wr_left > 0) begin
            check("wr_bank", bus.wr_en_2, tile_idx % 2);
            check("wr_demux", bus.ifm_demux, tile_idx % 2);
            if (bus.wr_en_1 === 1'b1) begin mem0.push_back(wr_data); n_wen1++; end
            if (bus.wr_en_2 === 1'b1) begin mem1.push_back(wr_data); n_wen2++; end
            tile_buf.push_back(wr_data);
            wr_data++;
            wr_left--;
            if (tile_buf.size() == len_cur) begin
                for (int r = 0; r < rep_cur; r++)
                    foreach (tile_buf[k]) exp_q.push_back('{data: tile_buf[k], bank: 1'(tile_idx % 2)});
                tile_buf.delete();
                tile_idx++;
            end
        end
    endtask

    task automatic drive();
        bus.wr_valid = (wr_left > 0);
        bus.rd_req   = rd_on;
    endtask

    task automatic tick();
        #1;
        observe();
        @(negedge clk);
        drive();
        #1;
    endtask

    task automatic start_session(input int len, input int rep);
        bus.start   = 1'b1;
        bus.cfg_len = 13'(len);
`ifdef IFM_REPLAY_EN
        bus.cfg_rep = 4'(rep);
`endif
        tick();
        bus.start = 1'b0;
        flush_model();
        len_cur = len;
        rep_cur = (rep == 0) ? 1 : rep;
    endtask

    task automatic run_drain(input int budget, input string tag);
        for (int i = 0; i < budget && (wr_left > 0 || exp_q.size() > 0 || rd_pend); i++) tick();
        check(tag, exp_q.size() + wr_left, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; bus.cfg_len = '0;
`ifdef IFM_REPLAY_EN
        bus.cfg_rep = '0;
`endif
        wr_left = 0; rd_on = 1'b0; cyc = 0; len_cur = 1; rep_cur = 1;
        flush_model();
        drive();
        @(negedge clk); #1;
        tick(); tick();
        check("reset_outputs", outs(), 0);

        // Session 1: cfg_len = 4, fill both banks then drain.
        rst_n = 1'b1;
        start_session(4, 1);
        check("start_clears", clrs(), 4'hF);
        check("start_busy", bus.busy, 1);
        check("clr_wr_ready", bus.wr_ready, 0);
        tick();
        check("post_clr_clears", clrs(), 4'h0);
        check("empty_wr_ready", bus.wr_ready, 1);

        wr_left = 8; drive();
        for (int i = 0; i < 40 && wr_left > 0; i++) tick();
        check("fill8_done", wr_left, 0);
        check("fill8_wen1", n_wen1, 4);
        check("fill8_wen2", n_wen2, 4);
        check("fill8_wr_ready_low", bus.wr_ready, 0);

        rd_on = 1'b1; drive();
        run_drain(60, "drain8_done");
        check("drain8_ren1", n_ren1, 4);
        check("drain8_ren2", n_ren2, 4);
        check("drain8_tiles", n_tile, 2);
        check("clr1_after_last_rd1", clr1_cyc - last_rd1_cyc, 1);
        rd_on = 1'b0; drive();
        tick(); tick();
        check("refill_wr_ready", bus.wr_ready, 1);

        // Session 2: cfg_len = 3, writes overlap reads of the other bank.
        start_session(3, 1);
        wr_left = 12; rd_on = 1'b1; drive();
        run_drain(200, "concurrent_done");
        check("concurrent_tiles", n_tile, 4);
        check("concurrent_overlap", n_overlap > 0, 1);

        // Illegal starts mid-fill must leave the session untouched.
        rd_on = 1'b0; n_tile = 0;
        wr_left = 1; drive();
        for (int i = 0; i < 10 && wr_left > 0; i++) tick();
        bus.start = 1'b1; bus.cfg_len = 13'd0;
        tick();
        bus.start = 1'b0;
        check("bad_start0_clears", clrs(), 4'h0);
        bus.start = 1'b1; bus.cfg_len = 13'd4609;
        tick();
        bus.start = 1'b0;
        check("bad_start_big_clears", clrs(), 4'h0);
        check("bad_start_busy", bus.busy, 1);
        wr_left = 2; rd_on = 1'b1; drive();
        run_drain(40, "bad_start_resume_done");
        check("bad_start_resume_tiles", n_tile, 1);

        // Session 3: maximum length fills bank 1 completely, then reset mid-drain.
        rd_on = 1'b0;
        start_session(4608, 1);
        wr_left = 4608; drive();
        for (int i = 0; i < 5000 && wr_left > 0; i++) tick();
        check("max_fill_wen1", n_wen1, 4608);
        check("max_fill_wen2", n_wen2, 0);
        check("max_fill_demux", bus.ifm_demux, 1);
        check("max_fill_wr_ready", bus.wr_ready, 1);
        rd_on = 1'b1; drive();
        for (int i = 0; i < 100; i++) tick();
        check("max_reads", n_ren1, 100);
        rst_n = 1'b0;
        tick();
        check("reset_mid_drain", outs(), 0);
        flush_model();
        rd_on = 1'b0; drive();
        rst_n = 1'b1;
        tick();

`ifdef IFM_REPLAY_EN
        // Replay: each word of bank 1 read three times.
        start_session(2, 3);
        wr_left = 2; rd_on = 1'b1; drive();
        run_drain(60, "replay_done");
        check("replay_ren1", n_ren1, 6);
        check("replay_rewinds", n_rewind1, 2);
        check("replay_tiles", n_tile, 1);
        rd_on = 1'b0; drive();
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
